// File: rtl/router_output_ctrl_pkg.sv
// Shared router constants and the polarity-to-buffer mapping used by both
// the input and output controllers.
package router_output_ctrl_pkg;

    localparam int unsigned ROUTER_DW = 64;

    localparam int unsigned REQ_RING = 0;
    localparam int unsigned REQ_PE   = 1;

    // polarity=1: internal side fills odd, external side uses even; polarity=0 the reverse.
    function automatic logic fill_is_odd(input logic polarity);
        return polarity;
    endfunction

endpackage

// File: rtl/router_output_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; pointer moves to the loser after every grant.
module rr_arb2
    import router_output_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
        // Priority passes to the requester that did not win.
        if (gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/router_output_ctrl.sv
// Router output controller: arbitrates ring/PE requesters into an even/odd
// double buffer and drains the opposite buffer onto the outgoing link.
module router_output_ctrl
    import router_output_ctrl_pkg::*;
#(
    parameter int unsigned DW = ROUTER_DW,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          polarity,
    input  logic          req0,
    input  logic [DW-1:0] din0,
    input  logic          req1,
    input  logic [DW-1:0] din1,
    output logic          ack0,
    output logic          ack1,
    input  logic          ro,
    output logic          so,
    output logic [DW-1:0] dout,
    output logic [CW-1:0] pkt_cnt
);

    logic [DW-1:0] even_buf_q, even_buf_d;
    logic [DW-1:0] odd_buf_q,  odd_buf_d;
    logic          even_full_q, even_full_d;
    logic          odd_full_q,  odd_full_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          fill_odd;
    logic          fill_ok;
    logic          send_full;
    logic [1:0]    gnt;
    logic          grant_any;
    logic [DW-1:0] fill_data;

    assign fill_odd  = fill_is_odd(polarity);
    assign fill_ok   = fill_odd ? !odd_full_q : !even_full_q;
    assign send_full = fill_odd ? even_full_q : odd_full_q;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (reset),
        .req_i ({req1, req0}),
        .en_i  (fill_ok),
        .gnt_o (gnt)
    );

    assign ack0      = gnt[REQ_RING];
    assign ack1      = gnt[REQ_PE];
    assign grant_any = |gnt;
    assign fill_data = gnt[REQ_PE] ? din1 : din0;

    assign so      = ro & send_full;
    assign dout    = fill_odd ? even_buf_q : odd_buf_q;
    assign pkt_cnt = cnt_q;

    // Fill and send always target different buffers, so both may happen in one cycle.
    always_comb begin
        even_buf_d  = even_buf_q;
        odd_buf_d   = odd_buf_q;
        even_full_d = even_full_q;
        odd_full_d  = odd_full_q;
        cnt_d       = cnt_q;
        if (grant_any) begin
            if (fill_odd) begin
                odd_buf_d  = fill_data;
                odd_full_d = 1'b1;
            end else begin
                even_buf_d  = fill_data;
                even_full_d = 1'b1;
            end
        end
        if (so) begin
            if (fill_odd) begin
                even_full_d = 1'b0;
            end else begin
                odd_full_d = 1'b0;
            end
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            even_buf_q  <= '0;
            odd_buf_q   <= '0;
            even_full_q <= 1'b0;
            odd_full_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            even_buf_q  <= even_buf_d;
            odd_buf_q   <= odd_buf_d;
            even_full_q <= even_full_d;
            odd_full_q  <= odd_full_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_router_output_ctrl.sv
// Directed bench for router_output_ctrl with immediate-assertion checks.
module tb_router_output_ctrl;

    localparam int unsigned DW = 64;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          polarity;
    logic          req0, req1;
    logic [DW-1:0] din0, din1;
    logic          ack0, ack1;
    logic          ro;
    logic          so;
    logic [DW-1:0] dout;
    logic [CW-1:0] pkt_cnt;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    router_output_ctrl #(.DW(DW), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .req0     (req0),
        .din0     (din0),
        .req1     (req1),
        .din1     (din1),
        .ack0     (ack0),
        .ack1     (ack1),
        .ro       (ro),
        .so       (so),
        .dout     (dout),
        .pkt_cnt  (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; polarity = 1'b0; req0 = 1'b0; req1 = 1'b0;
        din0 = '0; din1 = '0; ro = 1'b0;
        #1;
        chk("rst_so",   64'(so), 64'd0);
        chk("rst_ack0", 64'(ack0), 64'd0);
        chk("rst_ack1", 64'(ack1), 64'd0);
        chk("rst_cnt",  64'(pkt_cnt), 64'd0);
        tick();
        reset = 1'b1;

        // Single path: fill even, send on the next phase.
        polarity = 1'b0; req0 = 1'b1; din0 = 64'hA5A5; ro = 1'b0;
        #1;
        chk("sp_ack0", 64'(ack0), 64'd1);
        chk("sp_ack1", 64'(ack1), 64'd0);
        chk("sp_so0",  64'(so), 64'd0);
        tick();
        req0 = 1'b0; polarity = 1'b1; ro = 1'b1;
        #1;
        chk("sp_so",   64'(so), 64'd1);
        chk("sp_dout", dout, 64'hA5A5);
        tick();
        chk("sp_cnt",  64'(pkt_cnt), 64'd1);
        chk("sp_so_after", 64'(so), 64'd0);

        // Contention: pointer reset, then grants alternate 0,1,0,1...
        reset = 1'b0; #1; reset = 1'b1;
        chk("ct_cnt_rst", 64'(pkt_cnt), 64'd0);
        req0 = 1'b1; req1 = 1'b1; ro = 1'b1;
        for (int k = 0; k < 6; k++) begin
            polarity = k[0];
            din0 = 64'h100 + 64'(k);
            din1 = 64'h200 + 64'(k);
            #1;
            chk($sformatf("ct_ack0_%0d", k), 64'(ack0), (k % 2 == 0) ? 64'd1 : 64'd0);
            chk($sformatf("ct_ack1_%0d", k), 64'(ack1), (k % 2 == 1) ? 64'd1 : 64'd0);
            chk($sformatf("ct_so_%0d", k), 64'(so), (k > 0) ? 64'd1 : 64'd0);
            if (k > 0)
                chk($sformatf("ct_dout_%0d", k), dout,
                    ((k - 1) % 2 == 0) ? 64'h100 + 64'(k - 1) : 64'h200 + 64'(k - 1));
            chk($sformatf("ct_cnt_%0d", k), 64'(pkt_cnt), (k > 0) ? 64'(k - 1) : 64'd0);
            tick();
        end
        req0 = 1'b0; req1 = 1'b0; polarity = 1'b0;
        #1;
        chk("ct_tail_so",   64'(so), 64'd1);
        chk("ct_tail_dout", dout, 64'h205);
        tick();
        chk("ct_tail_cnt",  64'(pkt_cnt), 64'd6);

        // Back-pressure: ro low, both buffers fill, then acks stop.
        ro = 1'b0; req0 = 1'b1;
        polarity = 1'b0; din0 = 64'hAAA; #1;
        chk("bp_ack_a", 64'(ack0), 64'd1);
        chk("bp_so_a",  64'(so), 64'd0);
        tick();
        polarity = 1'b1; din0 = 64'hBBB; #1;
        chk("bp_ack_b", 64'(ack0), 64'd1);
        chk("bp_so_b",  64'(so), 64'd0);
        tick();
        polarity = 1'b0; din0 = 64'hCCC; #1;
        chk("bp_ack_c", 64'(ack0), 64'd0);
        chk("bp_so_c",  64'(so), 64'd0);
        tick();
        polarity = 1'b1; #1;
        chk("bp_ack_d", 64'(ack0), 64'd0);
        chk("bp_so_d",  64'(so), 64'd0);
        tick();
        req0 = 1'b0; ro = 1'b1; polarity = 1'b1; #1;
        chk("bp_drain1_so",   64'(so), 64'd1);
        chk("bp_drain1_dout", dout, 64'hAAA);
        tick();
        polarity = 1'b0; #1;
        chk("bp_drain2_so",   64'(so), 64'd1);
        chk("bp_drain2_dout", dout, 64'hBBB);
        tick();
        chk("bp_cnt", 64'(pkt_cnt), 64'd8);

        // Polarity stuck at 1: one ack, then back-pressure until it flips.
        ro = 1'b0; req0 = 1'b1; din0 = 64'hDD; polarity = 1'b1; #1;
        chk("st_ack_first", 64'(ack0), 64'd1);
        tick();
        chk("st_ack_hold1", 64'(ack0), 64'd0);
        tick();
        chk("st_ack_hold2", 64'(ack0), 64'd0);
        polarity = 1'b0; #1;
        chk("st_ack_flip", 64'(ack0), 64'd1);
        tick();

        // Reset with both buffers full and pointer favouring requester 1.
        req0 = 1'b0; ro = 1'b1; polarity = 1'b1;
        #1;
        chk("rs_pre_so", 64'(so), 64'd1);
        reset = 1'b0; #1;
        chk("rs_so",   64'(so), 64'd0);
        chk("rs_ack0", 64'(ack0), 64'd0);
        chk("rs_ack1", 64'(ack1), 64'd0);
        chk("rs_cnt",  64'(pkt_cnt), 64'd0);
        tick();
        chk("rs_so_held", 64'(so), 64'd0);
        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b1; #1;
        chk("rs_ptr_ack0", 64'(ack0), 64'd1);
        chk("rs_ptr_ack1", 64'(ack1), 64'd0);
        req0 = 1'b0; #1;
        chk("rs_req1_ack1", 64'(ack1), 64'd1);
        chk("rs_req1_so",   64'(so), 64'd0);
        req1 = 1'b0;

        // Counter wrap: 17 sends on a 4-bit counter.
        reset = 1'b0; #1; reset = 1'b1;
        req0 = 1'b1; ro = 1'b1;
        for (int k = 0; k < 18; k++) begin
            polarity = k[0];
            din0 = 64'h300 + 64'(k);
            tick();
        end
        req0 = 1'b0;
        chk("wrap_cnt", 64'(pkt_cnt), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
